// File: rtl/trivium_pkg.sv
// Trivium cipher definitions shared by the keystream core and its users.
//   - widths of the cipher state, key and IV, default warm-up length
//   - zero-based tap positions (s<n> lives at bit n-1)
//   - load and single-step functions, top-level FSM state enum
package trivium_pkg;

    localparam int unsigned STATE_BITS      = 288;
    localparam int unsigned KEY_BITS        = 80;
    localparam int unsigned IV_BITS         = 80;
    localparam int unsigned LEN_BITS        = 16;
    localparam int unsigned INIT_STEPS_DFLT = 1152;

    // Tap positions: S<n> is the bit index of Trivium's s<n>
    localparam int unsigned S66  = 65;
    localparam int unsigned S69  = 68;
    localparam int unsigned S91  = 90;
    localparam int unsigned S92  = 91;
    localparam int unsigned S93  = 92;
    localparam int unsigned S94  = 93;
    localparam int unsigned S162 = 161;
    localparam int unsigned S171 = 170;
    localparam int unsigned S175 = 174;
    localparam int unsigned S176 = 175;
    localparam int unsigned S177 = 176;
    localparam int unsigned S178 = 177;
    localparam int unsigned S243 = 242;
    localparam int unsigned S264 = 263;
    localparam int unsigned S286 = 285;
    localparam int unsigned S287 = 286;
    localparam int unsigned S288 = 287;

    typedef logic [STATE_BITS-1:0] tstate_t;

    typedef struct packed {
        tstate_t state;
        logic    z;
    } step_t;

    typedef enum logic [2:0] {
        IDLE,
        WARMUP,
        STREAM,
        DRAIN,
        DONE
    } fsm_t;

    // Initial state: key MSB-first into s1..s80, IV MSB-first into s94..s173, s286..s288 = 1
    function automatic tstate_t trivium_load(input logic [KEY_BITS-1:0] key,
                                             input logic [IV_BITS-1:0]  iv);
        tstate_t s;
        s = '0;
        for (int i = 0; i < 80; i++) begin
            s[i]       = key[79 - i];
            s[S94 + i] = iv[79 - i];
        end
        s[S288:S286] = 3'b111;
        return s;
    endfunction

    // One keystream step: output bit z and the shifted state
    function automatic step_t trivium_step(input tstate_t s);
        logic  t1;
        logic  t2;
        logic  t3;
        step_t r;
        t1  = s[S66]  ^ s[S93];
        t2  = s[S162] ^ s[S177];
        t3  = s[S243] ^ s[S288];
        r.z = t1 ^ t2 ^ t3;
        t1  = t1 ^ (s[S91]  & s[S92])  ^ s[S171];
        t2  = t2 ^ (s[S175] & s[S176]) ^ s[S264];
        t3  = t3 ^ (s[S286] & s[S287]) ^ s[S69];
        r.state = {s[S287:S178], t2, s[S176:S94], t1, s[S92:0], t3};
        return r;
    endfunction

endpackage

// File: rtl/trivium_keystream_core.sv
// Trivium keystream core: holds the 288-bit state, produces W keystream bits per cycle.
//   clk, reset  : clock, synchronous active-high reset (state cleared)
//   load_i      : load key_i/iv_i into the state (priority over advance_i)
//   advance_i   : step the state W times
//   z_word_c_o  : keystream word for the next W steps from the current state, first bit in MSB
module trivium_keystream_core
    import trivium_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic [KEY_BITS-1:0] key_i,
    input  logic [IV_BITS-1:0]  iv_i,
    input  logic                advance_i,
    output logic [W-1:0]        z_word_c_o
);

    tstate_t state_q;
    tstate_t state_d;
    tstate_t state_adv;
    step_t   st;

    // W unrolled steps; z_word is valid whether or not the caller advances
    always_comb begin
        state_adv  = state_q;
        z_word_c_o = '0;
        st         = '0;
        for (int i = 0; i < W; i++) begin
            st                   = trivium_step(state_adv);
            z_word_c_o[W-1-i]    = st.z;
            state_adv            = st.state;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = trivium_load(key_i, iv_i);
        end else if (advance_i) begin
            state_d = state_adv;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/trivium_decrypt_stream.sv
// Streaming Trivium decryptor: warm-up, then XOR ciphertext words with the keystream.
//   clk, reset          : clock, synchronous active-high reset
//   key, iv, len, start : message setup, sampled on start in IDLE (len in bits, floored to words)
//   ct_valid/ct_ready/ct_data : ciphertext input handshake, MSB is the earliest bit
//   pt_valid/pt_ready/pt_data : plaintext output handshake, MSB is the earliest bit
//   busy                : high while warming up, streaming or draining
//   done                : one-cycle pulse once the message is complete
module trivium_decrypt_stream
    import trivium_pkg::*;
#(
    parameter int unsigned W          = 8,
    parameter int unsigned INIT_STEPS = INIT_STEPS_DFLT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [KEY_BITS-1:0] key,
    input  logic [IV_BITS-1:0]  iv,
    input  logic [LEN_BITS-1:0] len,
    input  logic                start,
    input  logic                ct_valid,
    output logic                ct_ready,
    input  logic [W-1:0]        ct_data,
    output logic                pt_valid,
    input  logic                pt_ready,
    output logic [W-1:0]        pt_data,
    output logic                busy,
    output logic                done
);

    localparam int unsigned WARM_CYCLES = INIT_STEPS / W;
    localparam int unsigned CNT_W       = (WARM_CYCLES > 1) ? $clog2(WARM_CYCLES) : 1;
    localparam int unsigned W_LOG2      = $clog2(W);

    fsm_t                state_q, state_d;
    logic [LEN_BITS-1:0] words_left_q, words_left_d;
    logic [CNT_W-1:0]    warm_cnt_q, warm_cnt_d;
    logic                pt_valid_q, pt_valid_d;
    logic [W-1:0]        pt_data_q, pt_data_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic [LEN_BITS-1:0] msg_words;
    logic                core_load;
    logic                core_adv;
    logic                ct_accept;
    logic [W-1:0]        z_word;

    trivium_keystream_core #(.W(W)) u_core (
        .clk        (clk),
        .reset      (reset),
        .load_i     (core_load),
        .key_i      (key),
        .iv_i       (iv),
        .advance_i  (core_adv),
        .z_word_c_o (z_word)
    );

    // Floor of len/W; W is a power of two
    assign msg_words = len >> W_LOG2;

    // Next state, handshakes and output-register updates
    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        warm_cnt_d   = warm_cnt_q;
        pt_valid_d   = pt_valid_q;
        pt_data_d    = pt_data_q;
        done_d       = 1'b0;
        core_load    = 1'b0;
        core_adv     = 1'b0;
        ct_ready     = 1'b0;
        ct_accept    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    core_load    = 1'b1;
                    words_left_d = msg_words;
                    warm_cnt_d   = '0;
                    if (msg_words == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WARMUP;
                    end
                end
            end
            WARMUP: begin
                core_adv   = 1'b1;
                warm_cnt_d = warm_cnt_q + CNT_W'(1);
                if (warm_cnt_q == CNT_W'(WARM_CYCLES - 1)) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // The output slot is free if empty or being emptied this cycle
                ct_ready  = !pt_valid_q || pt_ready;
                ct_accept = ct_valid && ct_ready;
                if (pt_valid_q && pt_ready) begin
                    pt_valid_d = 1'b0;
                end
                if (ct_accept) begin
                    pt_data_d    = ct_data ^ z_word;
                    pt_valid_d   = 1'b1;
                    core_adv     = 1'b1;
                    words_left_d = words_left_q - LEN_BITS'(1);
                    if (words_left_q == LEN_BITS'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pt_valid_q && pt_ready) begin
                    pt_valid_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == WARMUP) || (state_d == STREAM) || (state_d == DRAIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            words_left_q <= '0;
            warm_cnt_q   <= '0;
            pt_valid_q   <= 1'b0;
            pt_data_q    <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            warm_cnt_q   <= warm_cnt_d;
            pt_valid_q   <= pt_valid_d;
            pt_data_q    <= pt_data_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign pt_valid = pt_valid_q;
    assign pt_data  = pt_data_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_trivium_decrypt_stream.sv
// Bench for trivium_decrypt_stream at W=8 against a bit-serial Trivium reference model.
module tb_trivium_decrypt_stream;

    localparam logic [79:0] KEY0 = 80'hFF000102030405060708;

    logic        clk = 1'b0;
    logic        reset;
    logic [79:0] key;
    logic [79:0] iv;
    logic [15:0] len;
    logic        start;
    logic        ct_valid;
    logic        ct_ready;
    logic [7:0]  ct_data;
    logic        pt_valid;
    logic        pt_ready;
    logic [7:0]  pt_data;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    trivium_decrypt_stream #(.W(8), .INIT_STEPS(1152)) dut (
        .clk      (clk),
        .reset    (reset),
        .key      (key),
        .iv       (iv),
        .len      (len),
        .start    (start),
        .ct_valid (ct_valid),
        .ct_ready (ct_ready),
        .ct_data  (ct_data),
        .pt_valid (pt_valid),
        .pt_ready (pt_ready),
        .pt_data  (pt_data),
        .busy     (busy),
        .done     (done)
    );

    int n_vec = 0;
    int n_err = 0;

    bit         ms[1:288];
    logic [7:0] ks_q[$];
    logic [7:0] ct_q[$];
    logic [7:0] out_q[$];
    logic [7:0] ptx_q[$];
    int busy_cycles, done_cnt, pv_seen, stall_bad, timed_out, cyc_to_done;

    // Reference: one Trivium step on the 1-based bit array ms
    task automatic model_step(output bit z);
        bit t1, t2, t3;
        t1 = ms[66]  ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91]  & ms[92])  ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int i = 93; i > 1; i--) ms[i] = ms[i-1];
        ms[1] = t3;
        for (int i = 177; i > 94; i--) ms[i] = ms[i-1];
        ms[94] = t1;
        for (int i = 288; i > 178; i--) ms[i] = ms[i-1];
        ms[178] = t2;
    endtask

    // Reference keystream bytes after warm-up, earliest bit in MSB
    task automatic model_keystream(input logic [79:0] k, input logic [79:0] v, input int nwords);
        bit         z;
        logic [7:0] b;
        for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            ms[i]      = k[80-i];
            ms[93 + i] = v[80-i];
        end
        ms[286] = 1'b1; ms[287] = 1'b1; ms[288] = 1'b1;
        repeat (1152) model_step(z);
        ks_q.delete();
        for (int w = 0; w < nwords; w++) begin
            b = 8'h00;
            for (int j = 0; j < 8; j++) begin
                model_step(z);
                b = {b[6:0], z};
            end
            ks_q.push_back(b);
        end
    endtask

    function automatic logic [79:0] rand80();
        return {16'($urandom()), $urandom(), $urandom()};
    endfunction

    // Runs one message: feeds ct_q, collects out_q and handshake statistics
    task automatic drive_msg(input logic [79:0] k, input logic [79:0] v, input logic [15:0] lbits,
                             input int gap_pct, input bit bp, input int abort_after, input int poke_at);
        int         idx, cyc, n_acc;
        bit         fin, stalled;
        logic [7:0] held;
        out_q.delete();
        busy_cycles = 0; done_cnt = 0; pv_seen = 0; stall_bad = 0; timed_out = 0; cyc_to_done = -1;
        idx = 0; cyc = 0; n_acc = 0; fin = 1'b0; stalled = 1'b0; held = 8'h00;
        @(negedge clk);
        key = k; iv = v; len = lbits; start = 1'b1; ct_valid = 1'b0; pt_ready = 1'b1;
        @(posedge clk);
        while (!fin) begin
            @(negedge clk);
            start = (cyc == poke_at);
            if (start) begin
                key = ~k;
                len = 16'd8;
            end
            pt_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            ct_valid = (idx < ct_q.size()) && ($urandom_range(99) >= gap_pct);
            ct_data  = (idx < ct_q.size()) ? ct_q[idx] : 8'h00;
            #1;
            if (stalled && (!pt_valid || pt_data !== held)) stall_bad++;
            stalled = pt_valid && !pt_ready;
            held    = pt_data;
            if (pt_valid) pv_seen++;
            if (busy) busy_cycles++;
            if (done) begin
                done_cnt++;
                if (cyc_to_done < 0) cyc_to_done = cyc;
                fin = 1'b1;
            end
            if (pt_valid && pt_ready) out_q.push_back(pt_data);
            if (ct_valid && ct_ready) begin
                idx++;
                n_acc++;
            end
            if (cyc >= 20000) begin
                timed_out = 1;
                fin = 1'b1;
            end
            cyc++;
            @(posedge clk);
            if (abort_after > 0 && n_acc == abort_after) fin = 1'b1;
        end
        #1;
        start = 1'b0;
        ct_valid = 1'b0;
        if (abort_after <= 0 && timed_out == 0) begin
            repeat (3) begin
                @(negedge clk);
                #1;
                if (done) done_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; ct_valid = 1'b0; pt_ready = 1'b0;
        key = '0; iv = '0; len = '0; ct_data = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (ct_ready !== 1'b0) begin n_err++; $display("FAIL reset_ct_ready: got %b expected 0", ct_ready); end
        n_vec++; if (pt_valid !== 1'b0) begin n_err++; $display("FAIL reset_pt_valid: got %b expected 0", pt_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_vec++; if (pt_data !== 8'h00) begin n_err++; $display("FAIL reset_pt_data: got %h expected 00", pt_data); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_round_trip();
        model_keystream(KEY0, 80'h0, 512);
        ct_q = ks_q;
        drive_msg(KEY0, 80'h0, 16'd4096, 0, 1'b0, 0, -1);
        n_vec++; if (timed_out !== 0) begin n_err++; $display("FAIL rt_timeout: got %0d expected 0", timed_out); end
        n_vec++; if (out_q.size() !== 512) begin n_err++; $display("FAIL rt_count: got %0d expected 512", out_q.size()); end
        for (int i = 0; i < out_q.size(); i++) begin
            n_vec++; if (out_q[i] !== 8'h00) begin n_err++; $display("FAIL rt_word[%0d]: got %h expected 00", i, out_q[i]); end
        end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL rt_done_pulses: got %0d expected 1", done_cnt); end
        n_vec++; if (busy_cycles !== 657) begin n_err++; $display("FAIL rt_busy_cycles: got %0d expected 657", busy_cycles); end
    endtask

    task automatic test_keystream();
        model_keystream(KEY0, 80'h0, 512);
        ct_q.delete();
        for (int i = 0; i < 512; i++) ct_q.push_back(8'h00);
        drive_msg(KEY0, 80'h0, 16'd4096, 0, 1'b0, 0, -1);
        n_vec++; if (out_q.size() !== 512) begin n_err++; $display("FAIL ks_count: got %0d expected 512", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 512; i++) begin
            n_vec++; if (out_q[i] !== ks_q[i]) begin n_err++; $display("FAIL ks_word[%0d]: got %h expected %h", i, out_q[i], ks_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        model_keystream(KEY0, 80'h0, 512);
        ct_q = ks_q;
        drive_msg(KEY0, 80'h0, 16'd4096, 0, 1'b1, 0, -1);
        n_vec++; if (out_q.size() !== 512) begin n_err++; $display("FAIL bp_count: got %0d expected 512", out_q.size()); end
        for (int i = 0; i < out_q.size(); i++) begin
            n_vec++; if (out_q[i] !== 8'h00) begin n_err++; $display("FAIL bp_word[%0d]: got %h expected 00", i, out_q[i]); end
        end
        n_vec++; if (stall_bad !== 0) begin n_err++; $display("FAIL bp_stall_stable: got %0d unstable cycles expected 0", stall_bad); end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL bp_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    // Random ct_valid gaps, random plaintext, and a start pulse while busy that must be ignored
    task automatic test_ct_gaps();
        logic [79:0] k, v;
        k = rand80(); v = rand80();
        model_keystream(k, v, 64);
        ptx_q.delete(); ct_q.delete();
        for (int i = 0; i < 64; i++) begin
            ptx_q.push_back(8'($urandom()));
            ct_q.push_back(ptx_q[i] ^ ks_q[i]);
        end
        drive_msg(k, v, 16'd512, 40, 1'b0, 0, 30);
        n_vec++; if (out_q.size() !== 64) begin n_err++; $display("FAIL gap_count: got %0d expected 64", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 64; i++) begin
            n_vec++; if (out_q[i] !== ptx_q[i]) begin n_err++; $display("FAIL gap_word[%0d]: got %h expected %h", i, out_q[i], ptx_q[i]); end
        end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL gap_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_len_edges();
        logic [79:0] k, v;
        ct_q.delete();
        drive_msg(KEY0, 80'h0, 16'd0, 0, 1'b0, 0, -1);
        n_vec++; if (cyc_to_done !== 0) begin n_err++; $display("FAIL len0_done_latency: got %0d expected 0", cyc_to_done); end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL len0_done_pulses: got %0d expected 1", done_cnt); end
        n_vec++; if (pv_seen !== 0) begin n_err++; $display("FAIL len0_pt_valid: got %0d expected 0", pv_seen); end
        n_vec++; if (busy_cycles !== 0) begin n_err++; $display("FAIL len0_busy: got %0d expected 0", busy_cycles); end

        model_keystream(KEY0, 80'h0, 1);
        ct_q.delete(); ct_q.push_back(8'hA5);
        drive_msg(KEY0, 80'h0, 16'd8, 0, 1'b0, 0, -1);
        n_vec++; if (out_q.size() !== 1) begin n_err++; $display("FAIL len8_count: got %0d expected 1", out_q.size()); end
        if (out_q.size() > 0) begin
            n_vec++; if (out_q[0] !== (8'hA5 ^ ks_q[0])) begin n_err++; $display("FAIL len8_word: got %h expected %h", out_q[0], 8'hA5 ^ ks_q[0]); end
        end

        // 29 bits floors to 3 words; a fourth word is offered but must not be taken
        k = rand80(); v = rand80();
        model_keystream(k, v, 4);
        ct_q.delete();
        for (int i = 0; i < 4; i++) ct_q.push_back(8'($urandom()));
        drive_msg(k, v, 16'd29, 0, 1'b0, 0, -1);
        n_vec++; if (out_q.size() !== 3) begin n_err++; $display("FAIL len29_count: got %0d expected 3", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 3; i++) begin
            n_vec++; if (out_q[i] !== (ct_q[i] ^ ks_q[i])) begin n_err++; $display("FAIL len29_word[%0d]: got %h expected %h", i, out_q[i], ct_q[i] ^ ks_q[i]); end
        end
        n_vec++; if (busy_cycles !== 148) begin n_err++; $display("FAIL len29_busy_cycles: got %0d expected 148", busy_cycles); end
    endtask

    task automatic test_reset_mid();
        logic [79:0] k, v;
        k = rand80(); v = rand80();
        model_keystream(k, v, 200);
        ptx_q.delete(); ct_q.delete();
        for (int i = 0; i < 200; i++) begin
            ptx_q.push_back(8'($urandom()));
            ct_q.push_back(ptx_q[i] ^ ks_q[i]);
        end
        drive_msg(k, v, 16'd1600, 20, 1'b0, 100, -1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (pt_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_pt_valid: got %b expected 0", pt_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_vec++; if (out_q.size() !== 99) begin n_err++; $display("FAIL rstmid_prefix_count: got %0d expected 99", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 200; i++) begin
            n_vec++; if (out_q[i] !== ptx_q[i]) begin n_err++; $display("FAIL rstmid_prefix[%0d]: got %h expected %h", i, out_q[i], ptx_q[i]); end
        end
        @(negedge clk);
        reset = 1'b0;
        drive_msg(k, v, 16'd1600, 20, 1'b0, 0, -1);
        n_vec++; if (out_q.size() !== 200) begin n_err++; $display("FAIL replay_count: got %0d expected 200", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 200; i++) begin
            n_vec++; if (out_q[i] !== ptx_q[i]) begin n_err++; $display("FAIL replay_word[%0d]: got %h expected %h", i, out_q[i], ptx_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_round_trip();
        test_keystream();
        test_backpressure();
        test_ct_gaps();
        test_len_edges();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/trivium_decrypt_stream.md
Name: trivium_decrypt_stream

Overview:
Streaming Trivium decryptor. It is the receive-side counterpart of the existing ENCRIPT block.
- Loads an 80-bit key and 80-bit IV, then runs the 1152-step warm-up.
- XORs incoming ciphertext words with the keystream and emits plaintext words under valid/ready handshakes.
- Bit-exact with ENCRIPT: for the same KEY/IV, ENCRIPT output fed in as ciphertext decrypts to plaintext.

Parameters:
W, 8, bits per word, also keystream steps per cycle; legal values 1, 2, 4, 8, 16, 32, 64
INIT_STEPS, 1152, warm-up steps (4x288); must be a multiple of W

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
key  in  80  cipher key, sampled on start
iv  in  80  initialisation vector, sampled on start
len  in  16  message length in bits, sampled on start; must be a multiple of W
start  in  1  one-cycle request to begin a message
ct_valid  in  1  ciphertext word valid
ct_ready  out  1  ciphertext word accepted when ct_valid&&ct_ready
ct_data  in  W  ciphertext word; MSB is the earliest bit
pt_valid  out  1  plaintext word valid
pt_ready  in  1  downstream ready
pt_data  out  W  plaintext word; MSB is the earliest bit
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when the last word is accepted downstream

Behaviour:
- Reset: state IDLE; outputs ct_ready, pt_valid, busy, done = 0; pt_data = 0; 288-bit state = 0.
- Load (start && IDLE):
  - s1..s80 = key[79:0] MSB first (s1 = key[79]); s81..s93 = 0.
  - s94..s173 = iv[79:0] MSB first; s174..s177 = 0.
  - s178..s285 = 0; s286..s288 = 1.
  - words_left = len/W.
- Step, one keystream bit:
  - t1 = s66^s93; t2 = s162^s177; t3 = s243^s288; z = t1^t2^t3.
  - t1 ^= (s91&s92)^s171; t2 ^= (s175&s176)^s264; t3 ^= (s286&s287)^s69.
  - Shift: s1..s93 <= t3,s1..s92; s94..s177 <= t1,s94..s176; s178..s288 <= t2,s178..s287.
  - W steps are unrolled per cycle; the first step's z lands in the word MSB.
- States:
  - IDLE: wait for start. If len==0, go straight to DONE with no warm-up. Otherwise go to WARMUP.
  - WARMUP: advance W steps per cycle for INIT_STEPS/W cycles (144 at W=8); z is discarded; then go to STREAM.
  - STREAM: ct_ready = !pt_valid || pt_ready.
    - On accept: pt_data <= ct_data ^ z_word, pt_valid <= 1, state advances W steps, words_left decrements.
    - The keystream advances only on accept.
    - After the final accept, go to DRAIN.
  - DRAIN: ct_ready = 0. Once the last pt word is taken (pt_valid&&pt_ready), pulse done and go to IDLE.
  - DONE (len==0 path only): pulse done for one cycle, then go to IDLE.
- Latency: ciphertext accept to pt_valid is 1 cycle. Full throughput is one word per cycle when pt_ready is held high.
- Backpressure: while pt_valid && !pt_ready, pt_data and the cipher state hold stable.
- Simultaneous accept and emit in the same cycle is legal: the old word leaves, the new word loads.
- start while busy is ignored; key, iv and len are not resampled.
- busy is 1 in WARMUP, STREAM and DRAIN.
- reset mid-message aborts immediately to IDLE with pt_valid = 0. A partially delivered message is not completed.
- len not a multiple of W: the low bits are ignored (floor).
- words_left is 16 bits, so there is no wrap at the maximum length.

Decomposition:
- Package trivium_pkg:
  - STATE_BITS=288, KEY_BITS=80, IV_BITS=80, INIT_STEPS default.
  - Tap-index constants.
  - A step function returning the next state and z.
  - State enum {IDLE, WARMUP, STREAM, DRAIN, DONE}.
- One sub-module, trivium_keystream_core:
  - Holds the 288-bit state.
  - Inputs: load, advance; outputs: a W-bit z_word.
  - Shared with the ENCRIPT rework.
- The top holds the FSM, counters and output register.

Test Plan:
- Round trip: KEY=80'hFF000102030405060708, IV=0, len=4096. Ciphertext is the 4096-bit ENCRIPT output, MSB first, in 512 bytes → all 512 pt bytes are 8'h00; done pulses once; busy high for 144 warm-up cycles + 512 + 1 cycles.
- Keystream extraction: same KEY/IV, ct all 8'h00 → pt stream equals ENCRIPT OUT bit-for-bit.
- Backpressure: pt_ready toggled with pattern 1,0,0,1 repeating. Expect pt_data stable while stalled, no word dropped or duplicated, and output identical to the round-trip test.
- ct_valid gaps with random idle cycles → keystream does not advance on idle cycles; result matches the round-trip test.
- len=0 → done pulses 1 cycle after start, no pt_valid, no warm-up. Then len=8, ct=8'hA5 → pt = 8'hA5 ^ first keystream byte.
- Reset at the 100th accepted word → next cycle pt_valid=0, busy=0. A new start replays from word 0 with identical output.
